// File: rtl/pmatch_pkg.sv
// Shared types and default sizing for the multi-pattern byte-stream matcher.
package pmatch_pkg;
  typedef logic [7:0] char_t;

  localparam int PMATCH_NPAT   = 4;
  localparam int PMATCH_MAXLEN = 8;
  localparam int PMATCH_CW     = 8;
endpackage

// File: rtl/pmatch_lane.sv
// One pattern lane: pattern/length/fill state, window compare, registered match pulse.
// Hit counter present only when MULTI_PATTERN_MATCHER_CNT_EN is defined.
module pmatch_lane
  import pmatch_pkg::*;
#(
  parameter int MAXLEN = PMATCH_MAXLEN,
  parameter int CW     = PMATCH_CW,
  localparam int QW    = $clog2(MAXLEN),
  localparam int LW    = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pat_we,
  input  logic              len_we,
  input  logic [QW-1:0]     cfg_pos,
  input  char_t             cfg_char,
  input  logic [LW-1:0]     cfg_len,
  input  logic              nonovl,
  input  logic              in_valid,
  input  logic [MAXLEN*8-1:0] win,
`ifdef MULTI_PATTERN_MATCHER_CNT_EN
  output logic [CW-1:0]     cnt,
`endif
  output logic              match
);

  localparam logic [LW-1:0] LEN_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LEN_MAX = LW'(MAXLEN);

  char_t         pat_r [MAXLEN];
  logic [LW-1:0] len_r;
  logic [LW-1:0] fill_r;
  logic          match_r;
  logic          eq_s;
  logic          hit_s;

  // Pattern char k must equal the window char of age len-1-k.
  always_comb begin
    eq_s = 1'b1;
    for (int k = 0; k < MAXLEN; k++) begin
      for (int a = 0; a < MAXLEN; a++) begin
        if ((k + a + 1 == int'(len_r)) && (pat_r[k] != win[a*8 +: 8])) begin
          eq_s = 1'b0;
        end else begin
          eq_s = eq_s;
        end
      end
    end
    hit_s = in_valid && (len_r != '0) && (fill_r >= (len_r - LEN_ONE)) && eq_s;
  end

  // Lane state; a config write clears fill and wins over the stream update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAXLEN; k++) begin
        pat_r[k] <= '0;
      end
      len_r   <= '0;
      fill_r  <= '0;
      match_r <= 1'b0;
    end else begin
      match_r <= hit_s;
      if (pat_we) begin
        pat_r[cfg_pos] <= cfg_char;
      end
      if (len_we) begin
        len_r <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      end
      if (pat_we || len_we) begin
        fill_r <= '0;
      end else if (hit_s && nonovl) begin
        fill_r <= '0;
      end else if (in_valid && (fill_r != LEN_MAX)) begin
        fill_r <= fill_r + LEN_ONE;
      end
    end
  end

  assign match = match_r;

`ifdef MULTI_PATTERN_MATCHER_CNT_EN
  logic [CW-1:0] cnt_r;

  // Saturating hit counter, steps on the edge that raises match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (hit_s && (cnt_r != '1)) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_r;
`endif

endmodule

// File: rtl/multi_pattern_matcher.sv
// Top: shared character history, config decode to per-pattern lanes, output concat.
// Optional per-pattern hit counters and cnt_o under MULTI_PATTERN_MATCHER_CNT_EN.
module multi_pattern_matcher
  import pmatch_pkg::*;
#(
  parameter int NPAT   = PMATCH_NPAT,
  parameter int MAXLEN = PMATCH_MAXLEN,
  parameter int CW     = PMATCH_CW,
  localparam int PW    = $clog2(NPAT),
  localparam int QW    = $clog2(MAXLEN),
  localparam int LW    = $clog2(MAXLEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_len_we,
  input  logic [PW-1:0]    cfg_sel,
  input  logic [QW-1:0]    cfg_pos,
  input  char_t            cfg_char,
  input  logic [LW-1:0]    cfg_len,
  input  logic             nonovl,
  input  logic             in_valid,
  input  char_t            in_char,
`ifdef MULTI_PATTERN_MATCHER_CNT_EN
  output logic [NPAT*CW-1:0] cnt_o,
`endif
  output logic [NPAT-1:0]  match_o
);

  // The oldest char a full-length pattern needs is at age MAXLEN-1, which is
  // the stored char one slot short of the newest shift position.
  logic [(MAXLEN-1)*8-1:0] hist_r;
  logic [MAXLEN*8-1:0]     win_s;

  assign win_s = {hist_r, in_char};

  // History shift register, advances only on accepted chars.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r <= '0;
    end else if (in_valid) begin
      hist_r <= win_s[(MAXLEN-1)*8-1:0];
    end
  end

  for (genvar p = 0; p < NPAT; p++) begin : g_lane
    pmatch_lane #(
      .MAXLEN (MAXLEN),
      .CW     (CW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .pat_we   (cfg_we && (cfg_sel == PW'(p))),
      .len_we   (cfg_len_we && (cfg_sel == PW'(p))),
      .cfg_pos  (cfg_pos),
      .cfg_char (cfg_char),
      .cfg_len  (cfg_len),
      .nonovl   (nonovl),
      .in_valid (in_valid),
      .win      (win_s),
`ifdef MULTI_PATTERN_MATCHER_CNT_EN
      .cnt      (cnt_o[p*CW +: CW]),
`endif
      .match    (match_o[p])
    );
  end

endmodule

// File: tb/tb_multi_pattern_matcher.sv
// Self-checking bench: stream-level reference model plus literal expectations.
module tb_multi_pattern_matcher;
  import pmatch_pkg::*;

  localparam int NPAT   = 4;
  localparam int MAXLEN = 8;
`ifdef MULTI_PATTERN_MATCHER_CNT_EN
  localparam int CW     = 2;
`else
  localparam int CW     = 8;
`endif
  localparam int PW = $clog2(NPAT);
  localparam int QW = $clog2(MAXLEN);
  localparam int LW = $clog2(MAXLEN + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_we = 1'b0;
  logic            cfg_len_we = 1'b0;
  logic [PW-1:0]   cfg_sel = '0;
  logic [QW-1:0]   cfg_pos = '0;
  logic [7:0]      cfg_char = '0;
  logic [LW-1:0]   cfg_len = '0;
  logic            nonovl = 1'b0;
  logic            in_valid = 1'b0;
  logic [7:0]      in_char = '0;
  logic [NPAT-1:0] match_o;
`ifdef MULTI_PATTERN_MATCHER_CNT_EN
  logic [NPAT*CW-1:0] cnt_o;
`endif

  multi_pattern_matcher #(.NPAT(NPAT), .MAXLEN(MAXLEN), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_len_we(cfg_len_we),
    .cfg_sel(cfg_sel), .cfg_pos(cfg_pos), .cfg_char(cfg_char), .cfg_len(cfg_len),
    .nonovl(nonovl), .in_valid(in_valid), .in_char(in_char),
`ifdef MULTI_PATTERN_MATCHER_CNT_EN
    .cnt_o(cnt_o),
`endif
    .match_o(match_o)
  );

  always #5 clk = ~clk;

  // Reference model: accepted stream since reset, per-pattern config and the
  // stream position at which each pattern's fill was last cleared.
  logic [7:0] strm [$];
  logic [7:0] pat_m [NPAT][MAXLEN];
  int len_m [NPAT];
  int clr_m [NPAT];
  int cnt_m [NPAT];
  int hits [NPAT];
  int first_hit [NPAT];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    strm.delete();
    for (int p = 0; p < NPAT; p++) begin
      for (int k = 0; k < MAXLEN; k++) pat_m[p][k] = 8'h00;
      len_m[p] = 0; clr_m[p] = 0; cnt_m[p] = 0; hits[p] = 0; first_hit[p] = 0;
    end
  endtask

  // One clock: model evaluates the accepted char with pre-write config, then
  // applies config writes; DUT outputs are compared 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] c);
    logic [NPAT-1:0] m;
    int n, l;
    bit ok;
    in_valid = v;
    in_char  = c;
    @(posedge clk);
    m = '0;
    n = strm.size();
    if (v) begin
      strm.push_back(c);
      n = strm.size();
      for (int p = 0; p < NPAT; p++) begin
        l = len_m[p];
        if (l > 0 && (n - clr_m[p]) >= l) begin
          ok = 1'b1;
          for (int k = 0; k < l; k++) if (pat_m[p][k] != strm[n - l + k]) ok = 1'b0;
          m[p] = ok;
        end
        if (m[p]) begin
          hits[p]++;
          if (first_hit[p] == 0) first_hit[p] = n;
          if (cnt_m[p] < (1 << CW) - 1) cnt_m[p]++;
          if (nonovl) clr_m[p] = n;
        end
      end
    end
    if (cfg_we) begin
      pat_m[cfg_sel][cfg_pos] = cfg_char;
      clr_m[cfg_sel] = n;
    end
    if (cfg_len_we) begin
      len_m[cfg_sel] = (int'(cfg_len) > MAXLEN) ? MAXLEN : int'(cfg_len);
      clr_m[cfg_sel] = n;
    end
    #1;
    cfg_we = 1'b0; cfg_len_we = 1'b0; in_valid = 1'b0;
    check("match_o", 32'(match_o), 32'(m));
`ifdef MULTI_PATTERN_MATCHER_CNT_EN
    for (int p = 0; p < NPAT; p++) check("cnt_o", 32'(cnt_o[p*CW +: CW]), 32'(cnt_m[p]));
`endif
  endtask

  task automatic prog(input int p, input string s);
    for (int i = 0; i < s.len(); i++) begin
      cfg_we = 1'b1; cfg_sel = PW'(p); cfg_pos = QW'(i); cfg_char = s[i];
      if (i == s.len() - 1) begin cfg_len_we = 1'b1; cfg_len = LW'(s.len()); end
      step(1'b0, 8'h00);
    end
    if (s.len() == 0) begin
      cfg_len_we = 1'b1; cfg_sel = PW'(p); cfg_len = '0;
      step(1'b0, 8'h00);
    end
  endtask

  task automatic send(input string s, input bit idle);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i]);
      if (idle) step(1'b0, 8'h00);
    end
  endtask

  task automatic do_reset();
    #2; rst = 1'b1; #1;
    check("async_rst_match", 32'(match_o), 32'h0);
    model_clear();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic prog_main();
    prog(0, "ABA"); prog(1, "MONIKA"); prog(2, "DE"); prog(3, "");
  endtask

  initial begin
    model_clear();
    #12;
    check("reset_match", 32'(match_o), 32'h0);
`ifdef MULTI_PATTERN_MATCHER_CNT_EN
    check("reset_cnt", 32'(cnt_o), 32'h0);
`endif
    @(negedge clk); rst = 1'b0;

    // Overlapping matches
    prog_main();
    nonovl = 1'b0;
    send("AABABA__JUSTMONIKA__CDEDE", 1'b0);
    check("ovl_p0_hits", hits[0], 2); check("ovl_p0_first", first_hit[0], 4);
    check("ovl_p1_hits", hits[1], 1); check("ovl_p1_first", first_hit[1], 18);
    check("ovl_p2_hits", hits[2], 2); check("ovl_p2_first", first_hit[2], 23);
    check("ovl_p3_hits", hits[3], 0);

    // Non-overlapping matches
    do_reset();
    prog_main();
    nonovl = 1'b1;
    send("AABABA__JUSTMONIKA__CDEDE", 1'b0);
    check("novl_p0_hits", hits[0], 1); check("novl_p0_first", first_hit[0], 4);
    check("novl_p1_hits", hits[1], 1); check("novl_p2_hits", hits[2], 2);

    // Idle cycle between every char
    do_reset();
    prog_main();
    nonovl = 1'b0;
    send("AABABA__JUSTMONIKA__CDEDE", 1'b1);
    check("idle_p0_hits", hits[0], 2); check("idle_p1_first", first_hit[1], 18);
    check("idle_p2_hits", hits[2], 2);

    // Reset mid-stream, then reprogram
    do_reset();
    prog(0, "ABA");
    send("ABA", 1'b0);
    check("pre_rst_p0_hits", hits[0], 1);
    do_reset();
    send("BA", 1'b0);
    check("post_rst_p0_hits", hits[0], 0);
    prog(0, "ABA");
    send("ABA", 1'b0);
    check("reprog_p0_hits", hits[0], 1);

    // Length rewrite coinciding with the completing char
    do_reset();
    prog(0, "ABA");
    send("AB", 1'b0);
    cfg_len_we = 1'b1; cfg_sel = '0; cfg_len = LW'(2);
    step(1'b1, "A");
    check("lenwr_old_len_hit", hits[0], 1);
    send("B", 1'b0);
    check("lenwr_fill_cleared", hits[0], 1);
    send("AB", 1'b0);
    check("lenwr_new_len_hit", hits[0], 2);

    // Length above MAXLEN clamps
    do_reset();
    prog(3, "ABCDEFGH");
    cfg_len_we = 1'b1; cfg_sel = PW'(3); cfg_len = LW'(15);
    step(1'b0, 8'h00);
    send("XABCDEFGH", 1'b0);
    check("clamp_p3_hits", hits[3], 1);

`ifdef MULTI_PATTERN_MATCHER_CNT_EN
    do_reset();
    prog(0, "A");
    send("AAAAA", 1'b0);
    check("cnt_sat_p0", 32'(cnt_o[CW-1:0]), 32'd3);
`endif

    // Randomised traffic with live config writes and mode changes
    do_reset();
    for (int p = 0; p < NPAT; p++) begin
      int l;
      l = int'($urandom_range(1, 3));
      for (int i = 0; i < l; i++) begin
        cfg_we = 1'b1; cfg_sel = PW'(p); cfg_pos = QW'(i);
        cfg_char = 8'h41 + 8'($urandom_range(0, 1));
        if (i == l - 1) begin cfg_len_we = 1'b1; cfg_len = LW'(l); end
        step(1'b0, 8'h00);
      end
    end
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) nonovl = ~nonovl;
      if ($urandom_range(0, 19) == 0) begin
        cfg_we = 1'b1; cfg_sel = PW'($urandom_range(0, NPAT - 1));
        cfg_pos = QW'($urandom_range(0, 3)); cfg_char = 8'h41 + 8'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 29) == 0) begin
        cfg_len_we = 1'b1; cfg_sel = PW'($urandom_range(0, NPAT - 1));
        cfg_len = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(0, 4));
      end
      step($urandom_range(0, 3) != 0, 8'h41 + 8'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_pattern_matcher.md
# multi_pattern_matcher

Byte-stream matcher that checks every accepted character against `NPAT` runtime-programmable patterns of up to `MAXLEN` characters each. Each match produces a per-pattern registered pulse, with overlapping or non-overlapping match semantics. It is the parametrised successor of the single fixed-pattern character detector and sits behind the character-stream source in the pattern testbench. Optional saturating per-pattern hit counters are compiled in by macro.

## Interface
Parameters:
- `NPAT`, 4: number of patterns (≥2)
- `MAXLEN`, 8: max pattern length in chars (≥2)
- `CW`, 8: hit-counter width

Ports (PW=$clog2(NPAT), QW=$clog2(MAXLEN), LW=$clog2(MAXLEN+1)):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_we`  in  1  write one pattern char
- `cfg_len_we`  in  1  write one pattern length
- `cfg_sel`  in  PW  target pattern
- `cfg_pos`  in  QW  char position (0 = first char of pattern)
- `cfg_char`  in  8  char data
- `cfg_len`  in  LW  length data; 0 disables pattern
- `nonovl`  in  1  1 = non-overlapping matches
- `in_valid`  in  1  `in_char` valid this cycle
- `in_char`  in  8  stream character
- `match_o`  out  NPAT  per-pattern match pulse
- `cnt_o`  out  NPAT*CW  hit counters, pattern p at [p*CW +: CW] (only with macro)

## Operation
- History: `MAXLEN`-deep shift register; on `in_valid`, hist[0]←in_char, hist[k]←hist[k-1].
- Pattern p matches on an accepted char when:
  - len[p]≠0;
  - pat[p][k] == stream char at age len[p]-1-k for all k<len[p] (age 0 = current `in_char`);
  - fill[p]+1 ≥ len[p].
- fill[p]: chars seen since reset/clear, saturates at `MAXLEN`. Increments on each accepted char.
- Overlap mode (`nonovl`=0): fill is not cleared on match, so "ABA" in "AABABA" hits twice.
- Non-overlap mode (`nonovl`=1): on a match, fill[p]←0 instead of incrementing, so "ABA" in "AABABA" hits once.
- Config:
  - `cfg_we` writes pat[cfg_sel][cfg_pos]; `cfg_len_we` writes len[cfg_sel]. Both may be asserted in the same cycle.
  - Either write clears fill[cfg_sel].
  - `cfg_len` > `MAXLEN` is clamped to `MAXLEN`.
- Simultaneous config write and `in_valid`: comparison uses pre-write pattern/length; clearing fill takes priority over incrementing it. History still shifts.
- `nonovl` is sampled per char and may change at any time.

## Timing
- `match_o[p]` is registered: high exactly one cycle after the accepting edge of the completing char, and low in any cycle following a non-accepting edge.
- Back-to-back chars produce back-to-back pulses.
- Reset values: hist, pat, len, fill, `match_o`, `cnt_o` all 0. All patterns are disabled after reset.
- Reset mid-stream: all state cleared immediately (asynchronous); the first post-reset match needs len fresh chars.
- Counter increments on the same edge that sets `match_o`. Saturates at 2^CW-1, no wrap.

## Configuration
- `MULTI_PATTERN_MATCHER_CNT_EN` defined: per-pattern CW-bit saturating hit counters present, `cnt_o` port exists.
- Not defined: counters and `cnt_o` absent. Matching behaviour is identical either way.

## Structure
- Package `pmatch_pkg`:
  - `char_t` (logic [7:0]);
  - default constants `PMATCH_NPAT`, `PMATCH_MAXLEN`, `PMATCH_CW`.
- Sub-module `pmatch_lane`, instantiated once per pattern. Each lane holds pat/len/fill (and the counter when enabled), compares against the shared history, and registers its `match_o` bit.
- Top level holds the history shift register, decodes cfg to lanes, and concatenates lane outputs.

## Test plan
- Program p0="ABA", p1="MONIKA", p2="DE", p3 len 0; `nonovl`=0; stream "AABABA__JUSTMONIKA__CDEDE" one char/cycle:
  - p0 pulses 2× (after chars 4 and 6), p1 1× (after char 18), p2 2× (after chars 23 and 25), p3 never.
- Same stream with `nonovl`=1 -> p0 pulses once (after char 4); p1 and p2 unchanged.
- Insert idle cycles (`in_valid`=0) between every char -> same match sequence; `match_o` is 0 on every cycle after an idle edge.
- Assert `rst` after char 3 of "ABA", then stream "BA" -> no p0 match. After reset, len is 0, so p0 must be reprogrammed to "ABA" before the following "ABA", which then matches once.
- Rewrite p0 length while its final char arrives in the same cycle -> match evaluated against the old length; fill cleared, so the next match needs len fresh chars.
- With `MULTI_PATTERN_MATCHER_CNT_EN`, CW=2, p0="A", stream 5×"A" -> `cnt_o` for p0 reads 1,2,3,3,3.
